// File: rtl/cmd_sched_pkg.sv
// Shared types for the SPI command scheduler: opcodes, queued tile-command
// entries and the write-scheduler FSM states.
package cmd_pkg;

    localparam int TILE_ADDR_W = 10;
    localparam int TILE_DATA_W = 8;

    typedef enum logic [3:0] {
        OP_NOP       = 4'h0,
        OP_WR_TILE   = 4'h1,
        OP_SET_SCORE = 4'h2,
        OP_SET_STATE = 4'h3,
        OP_CLEAR     = 4'h4
    } opcode_e;

    typedef enum logic {
        ENT_WR  = 1'b0,
        ENT_CLR = 1'b1
    } entry_kind_e;

    typedef struct packed {
        entry_kind_e            kind;
        logic [TILE_ADDR_W-1:0] addr;
        logic [TILE_DATA_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } fsm_state_e;

endpackage

// File: rtl/cmd_sched_if.sv
// SPI frame inputs, VGA read port and tile-RAM/status outputs of cmd_sched.
// master drives the SPI and VGA side; slave is the scheduler itself.
interface cmd_sched_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              cs;
    logic [7:0]        command;
    logic [7:0]        databyte1;
    logic [7:0]        databyte2;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [15:0]       state;
    logic [9:0]        score;
    logic              busy;
    logic              cmd_err;

    modport master (
        output cs, command, databyte1, databyte2, re, raddr,
        input  mem_we, mem_addr, mem_wdata, state, score, busy, cmd_err
    );

    modport slave (
        input  cs, command, databyte1, databyte2, re, raddr,
        output mem_we, mem_addr, mem_wdata, state, score, busy, cmd_err
    );
endinterface

// File: rtl/cmd_sched_sync_fifo.sv
// Small synchronous FIFO with a combinational head read. A push into a full
// FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which
    // entries are valid, so the array maps onto plain RAM/LUT cells.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cmd_sched.sv
// SPI command decoder and tile-RAM write scheduler; VGA reads always own the
// single memory port and queued writes/clears fill the idle cycles.
module cmd_sched
    import cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = TILE_ADDR_W,
    parameter int DATA_W     = TILE_DATA_W
) (
    input  logic       clk,
    input  logic       reset,
    cmd_sched_if.slave bus
);

    logic              cs_s1, cs_s2, cs_s3;
    logic              frame_v;
    opcode_e           op;
    logic [9:0]        score_q;
    logic [15:0]       state_q;
    logic              push_req;
    fifo_entry_t       push_entry;
    logic              cmd_err_q;
    fifo_entry_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    fsm_state_e        fsm;
    logic              wr_act;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wdata;

    // Synchronizer idles high so reset release never looks like a frame end.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            frame_v <= 1'b0;
        end else begin
            cs_s1   <= bus.cs;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            frame_v <= cs_s2 & ~cs_s3;
        end
    end

    assign op = opcode_e'(bus.command[7:4]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q    <= '0;
            state_q    <= '0;
            push_req   <= 1'b0;
            push_entry <= '0;
            cmd_err_q  <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            // A queued command that finds no free slot is dropped and flagged.
            cmd_err_q <= push_req & fifo_full & ~fifo_pop;
            if (frame_v) begin
                case (op)
                    OP_NOP: ;
                    OP_WR_TILE: begin
                        push_req   <= 1'b1;
                        push_entry <= '{kind: ENT_WR,
                                        addr: {bus.command[1:0], bus.databyte1},
                                        data: bus.databyte2};
                    end
                    OP_SET_SCORE: score_q <= {bus.command[1:0], bus.databyte1};
                    OP_SET_STATE: state_q <= {bus.databyte1, bus.databyte2};
                    OP_CLEAR: begin
                        push_req   <= 1'b1;
                        push_entry <= '{kind: ENT_CLR, addr: '0, data: bus.databyte2};
                    end
                    default: cmd_err_q <= 1'b1;
                endcase
            end
        end
    end

    assign fifo_pop = (fsm == IDLE) & ~fifo_empty;

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push_req),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm     <= IDLE;
            wr_act  <= 1'b0;
            wr_addr <= '0;
            wdata   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (!fifo_empty) begin
                        wr_act <= 1'b1;
                        wdata  <= head.data;
                        if (head.kind == ENT_WR) begin
                            fsm     <= WRITE;
                            wr_addr <= head.addr;
                        end else begin
                            fsm     <= CLEAR;
                            wr_addr <= '0;
                        end
                    end
                end
                WRITE: begin
                    if (!bus.re) begin
                        fsm    <= IDLE;
                        wr_act <= 1'b0;
                    end
                end
                CLEAR: begin
                    // Address only advances on cycles where the write really lands.
                    if (!bus.re) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (&wr_addr) begin
                            fsm    <= IDLE;
                            wr_act <= 1'b0;
                        end
                    end
                end
                default: begin
                    fsm    <= IDLE;
                    wr_act <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_we    = ~bus.re & wr_act;
    assign bus.mem_addr  = bus.re ? bus.raddr : wr_addr;
    assign bus.mem_wdata = wdata;
    assign bus.state     = state_q;
    assign bus.score     = score_q;
    assign bus.busy      = (fsm != IDLE) | ~fifo_empty;
    assign bus.cmd_err   = cmd_err_q;

endmodule
